tsv_repair_ctrl: RTL and testbench

Sequencer for the local FNS TSV-repair datapath on a 9-TSV (x=2, y=7) bundle. It collects per-TSV fault flags from a serial BIST scan chain and accumulates them in a sticky fault map. It drives the fault vector into the combinational FNS enable-flag adder chain and waits for it to settle. It then validates the returned enable vector and publishes it to the link codec through a valid/ready handshake.

---
 rtl/tsv_repair_ctrl_pkg.sv | 19 +
 rtl/tsv_popcount.sv | 13 +
 rtl/tsv_repair_ctrl.sv | 121 ++++++++++++
 tb/tb_tsv_repair_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tsv_repair_ctrl_pkg.sv
// tsv_repair_ctrl_pkg: shared constants and FSM encoding for the FNS TSV-repair sequencer.
package tsv_repair_ctrl_pkg;
    localparam int FNS_X          = 2;
    localparam int FNS_Y          = 7;
    localparam int DEF_N_TSV      = FNS_X + FNS_Y;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_MIN_EN     = 7;
    localparam int DEF_CNT_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_APPLY,
        S_CHECK,
        S_CFG,
        S_DONE,
        S_FAIL
    } state_t;
endpackage

// File: rtl/tsv_popcount.sv
// tsv_popcount: combinational population count of an N-bit flag vector.
module tsv_popcount #(
    parameter int N = 9,
    parameter int W = 4
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N; i++) o_cnt = o_cnt + W'(i_vec[i]);
    end
endmodule

// File: rtl/tsv_repair_ctrl.sv
// tsv_repair_ctrl: scans BIST fault flags into a sticky map, drives the external FNS
// adder chain, validates its enable vector and hands it to the link codec.
module tsv_repair_ctrl
    import tsv_repair_ctrl_pkg::*;
#(
    parameter int N_TSV      = DEF_N_TSV,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int MIN_EN     = DEF_MIN_EN,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_clear_faults,
    input  logic             i_scan_bit,
    input  logic             i_scan_valid,
    output logic             o_scan_ready,
    output logic [N_TSV-1:0] o_f_flag,
    input  logic [N_TSV-1:0] i_en_flag_in,
    output logic [N_TSV-1:0] o_en_flag_cfg,
    output logic             o_cfg_valid,
    input  logic             i_cfg_ready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_en_count,
    output logic             o_repair_ok,
    output logic             o_repair_fail
);
    state_t             r_state;
    logic [N_TSV-1:0]   r_map, r_f_flag, r_en_cfg;
    logic [CNT_W-1:0]   r_cnt, r_en_count;
    logic [3:0]         r_settle;
    logic               r_scan_ready, r_cfg_valid, r_busy, r_ok, r_fail, r_err, r_decide;
    logic               w_beat, w_last;
    logic [N_TSV-1:0]   w_map_nxt;
    logic [CNT_W-1:0]   w_pop;

    tsv_popcount #(.N(N_TSV), .W(CNT_W)) u_pop (.i_vec(i_en_flag_in), .o_cnt(w_pop));

    assign w_beat    = i_scan_valid & r_scan_ready;
    assign w_last    = r_cnt == CNT_W'(N_TSV - 1);
    assign w_map_nxt = r_map | (N_TSV'(i_scan_bit) << r_cnt);

    // CHECK spends one cycle capturing and one deciding from the captured values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_map        <= '0;
            r_f_flag     <= '0;
            r_en_cfg     <= '0;
            r_cnt        <= '0;
            r_en_count   <= '0;
            r_settle     <= '0;
            r_scan_ready <= 1'b0;
            r_cfg_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_ok         <= 1'b0;
            r_fail       <= 1'b0;
            r_err        <= 1'b0;
            r_decide     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (i_clear_faults) r_map <= '0;
                    if (i_start) begin
                        r_state      <= S_SCAN;
                        r_cnt        <= '0;
                        r_ok         <= 1'b0;
                        r_fail       <= 1'b0;
                        r_scan_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_SCAN: if (w_beat) begin
                    r_map <= w_map_nxt;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_state      <= S_APPLY;
                        r_scan_ready <= 1'b0;
                        r_f_flag     <= w_map_nxt;
                        r_settle     <= '0;
                    end
                end
                S_APPLY: begin
                    r_settle <= r_settle + 1'b1;
                    if (r_settle == 4'(SETTLE_CYC - 1)) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_decide <= !r_decide;
                    if (!r_decide) begin
                        r_en_cfg   <= i_en_flag_in;
                        r_en_count <= w_pop;
                        r_err      <= |(i_en_flag_in & r_f_flag);
                    end else if (r_err || r_en_count < CNT_W'(MIN_EN)) begin
                        r_state <= S_FAIL;
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state     <= S_CFG;
                        r_cfg_valid <= 1'b1;
                    end
                end
                S_CFG: if (i_cfg_ready) begin
                    r_state     <= S_DONE;
                    r_cfg_valid <= 1'b0;
                    r_ok        <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_scan_ready  = r_scan_ready;
    assign o_f_flag      = r_f_flag;
    assign o_en_flag_cfg = r_en_cfg;
    assign o_cfg_valid   = r_cfg_valid;
    assign o_busy        = r_busy;
    assign o_en_count    = r_en_count;
    assign o_repair_ok   = r_ok;
    assign o_repair_fail = r_fail;
endmodule

// File: tb/tb_tsv_repair_ctrl.sv
// tb_tsv_repair_ctrl: directed passes through the repair sequencer with a constant
// enable-vector stub standing in for the FNS adder chain.
module tb_tsv_repair_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, clear_faults = 1'b0, scan_bit = 1'b0, scan_valid = 1'b0;
    logic       cfg_ready = 1'b0;
    logic [8:0] en_stub = '0;
    logic       scan_ready, cfg_valid, busy, repair_ok, repair_fail;
    logic [8:0] f_flag, en_flag_cfg;
    logic [3:0] en_count;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    tsv_repair_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_clear_faults(clear_faults),
        .i_scan_bit(scan_bit), .i_scan_valid(scan_valid), .o_scan_ready(scan_ready),
        .o_f_flag(f_flag), .i_en_flag_in(en_stub), .o_en_flag_cfg(en_flag_cfg),
        .o_cfg_valid(cfg_valid), .i_cfg_ready(cfg_ready), .o_busy(busy),
        .o_en_count(en_count), .o_repair_ok(repair_ok), .o_repair_fail(repair_fail)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of cycle 14 (start cycle = 0)
    task automatic pass(input logic [8:0] flt, input logic clr, input logic [8:0] en,
                        input logic [8:0] exp_f, input logic exp_cfg);
        en_stub = en;
        start = 1'b1;
        clear_faults = clr;
        @(negedge clk);
        start = 1'b0;
        clear_faults = 1'b0;
        chk("scan_ready", scan_ready, 1);
        chk("busy_scan", busy, 1);
        for (int i = 0; i < 9; i++) begin
            scan_valid = 1'b1;
            scan_bit = flt[i];
            @(negedge clk);
        end
        scan_valid = 1'b0;
        scan_bit = 1'b0;
        chk("scan_ready_off", scan_ready, 0);
        chk("f_flag", f_flag, exp_f);
        repeat (3) @(negedge clk);
        chk("cfg_valid_c13", cfg_valid, 0);
        @(negedge clk);
        chk("cfg_valid_c14", cfg_valid, exp_cfg);
    endtask

    initial begin
        #1;
        chk("rst_scan_ready", scan_ready, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_f_flag", f_flag, 0);
        chk("rst_en_cfg", en_flag_cfg, 0);
        chk("rst_en_count", en_count, 0);
        chk("rst_ok_fail", {repair_ok, repair_fail}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fault-free, ready already high
        cfg_ready = 1'b1;
        pass(9'h000, 1'b0, 9'h07F, 9'h000, 1'b1);
        chk("ff_en_cfg", en_flag_cfg, 9'h07F);
        chk("ff_en_count", en_count, 7);
        @(negedge clk);
        chk("ff_cfg_drop", cfg_valid, 0);
        chk("ff_ok", repair_ok, 1);
        chk("ff_busy", busy, 0);

        // single fault on TSV3
        pass(9'h008, 1'b1, 9'h1F7, 9'h008, 1'b1);
        chk("s3_en_count", en_count, 8);
        @(negedge clk);
        chk("s3_ok", repair_ok, 1);
        chk("s3_fail", repair_fail, 0);

        // too few enabled TSVs
        pass(9'h00F, 1'b1, 9'h1F0, 9'h00F, 1'b0);
        chk("few_fail", repair_fail, 1);
        chk("few_ok", repair_ok, 0);
        chk("few_en_count", en_count, 5);
        chk("few_en_cfg", en_flag_cfg, 9'h1F0);
        repeat (3) begin
            @(negedge clk);
            chk("few_no_valid", cfg_valid, 0);
        end

        // adder enables a faulty TSV
        pass(9'h002, 1'b1, 9'h0FF, 9'h002, 1'b0);
        chk("inc_fail", repair_fail, 1);
        chk("inc_busy", busy, 0);

        // sticky map: TSV5 from pass 1 survives a clean pass 2, with backpressure
        pass(9'h020, 1'b1, 9'h1DF, 9'h020, 1'b1);
        @(negedge clk);
        chk("st1_ok", repair_ok, 1);
        cfg_ready = 1'b0;
        pass(9'h000, 1'b0, 9'h1DF, 9'h020, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", cfg_valid, 1);
            chk("bp_data", en_flag_cfg, 9'h1DF);
            chk("bp_ok", repair_ok, 0);
        end
        cfg_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", cfg_valid, 0);
        chk("bp_done_ok", repair_ok, 1);

        // clear together with start wipes the sticky map first
        pass(9'h000, 1'b1, 9'h07F, 9'h000, 1'b1);
        @(negedge clk);
        chk("clr_ok", repair_ok, 1);

        // reset during beat 4 of SCAN, then a clean pass
        pass(9'h000, 1'b0, 9'h07F, 9'h000, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_valid = 1'b1;
            scan_bit = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("rs_scan_ready", scan_ready, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ok", repair_ok, 0);
        scan_valid = 1'b0;
        scan_bit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pass(9'h000, 1'b0, 9'h07F, 9'h000, 1'b1);
        @(negedge clk);
        chk("rs_clean_ok", repair_ok, 1);

        // reset while offering a configuration
        cfg_ready = 1'b0;
        pass(9'h010, 1'b0, 9'h1EF, 9'h010, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rc_cfg_valid", cfg_valid, 0);
        chk("rc_en_cfg", en_flag_cfg, 0);
        chk("rc_en_count", en_count, 0);
        chk("rc_f_flag", f_flag, 0);
        chk("rc_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_ready = 1'b1;
        @(negedge clk);
        pass(9'h000, 1'b0, 9'h07F, 9'h000, 1'b1);
        @(negedge clk);
        chk("rc_clean_ok", repair_ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
